alu_share_arbiter: RTL and testbench

- Shares one combinational ArithmeticLogicUnit between two requesters: port 0 is the EX-stage datapath, port 1 is the auxiliary address/branch unit.
- Arbitrates per cycle with round-robin priority.
- Drives the ALU operand and control inputs, then registers the ALU result and overflow into a single response holding register.
- The response is returned with a requester ID under a valid/ready handshake.

---
 rtl/alu_share_arbiter.sv | 104 ++++++++++
 tb/tb_alu_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between the EX datapath (port 0)
// and the auxiliary address/branch unit (port 1), with a one-entry response register.
module alu_share_arbiter #(
  parameter logic [3:0]  PARKED_CTRL = 4'd0,
  parameter int unsigned ID_W        = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic [3:0]      req0_ctrl,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic [3:0]      req1_ctrl,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [31:0]     alu_out,
  input  logic            alu_overflow,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_data,
  output logic            rsp_overflow,
  input  logic            flush
);

  // Handshakes: a transfer happens on any edge where valid & ready are both 1.
  // Requesters hold valid/operands until ready; the response register holds
  // rsp_* stable while rsp_valid & ~rsp_ready.

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic            can_issue;
  logic            prefer1;
  logic            gnt0, gnt1, gnt_any;

  // A new op may issue in the same cycle the held response drains.
  assign can_issue = ~flush & ((state_q == EMPTY) | rsp_ready);
  assign prefer1   = (last_grant == ID_W'(0));
  assign gnt0      = can_issue & req0_valid & (~req1_valid | ~prefer1);
  assign gnt1      = can_issue & req1_valid & (~req0_valid | prefer1);
  assign gnt_any   = gnt0 | gnt1;
  assign gnt_idx   = gnt1 ? ID_W'(1) : ID_W'(0);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == FULL);

  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctrl = PARKED_CTRL;
    if (gnt0) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (gnt1) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = EMPTY;
    else if (gnt_any)
      state_d = FULL;
    else if ((state_q == FULL) && rsp_ready)
      state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Data registers only move on a grant; after a flush they may hold stale values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id       <= '0;
      rsp_data     <= 32'd0;
      rsp_overflow <= 1'b0;
      last_grant   <= ID_W'(1);
    end else if (gnt_any) begin
      rsp_id       <= gnt_idx;
      rsp_data     <= alu_out;
      rsp_overflow <= alu_overflow;
      last_grant   <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and random checks of alu_share_arbiter against a cycle-level model
// of the arbitration rules and a one-entry response scoreboard.
module tb_alu_share_arbiter;

  localparam logic [3:0] PARK    = 4'hF;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctrl;
  logic        alu_overflow;
  logic        rsp_valid, rsp_ready, rsp_overflow, flush;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_data;

  int   total = 0;
  int   bad   = 0;
  logic m_last;
  logic [33:0] exp_q[$];

  alu_share_arbiter #(.PARKED_CTRL(PARK), .ID_W(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_overflow(rsp_overflow), .flush(flush)
  );

  // Returns {overflow, result}; overflow is only defined for add/sub.
  function automatic logic [32:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c);
    logic [31:0] s;
    logic        v;
    s = 32'd0;
    v = 1'b0;
    case (c)
      OP_ADD:  begin s = a + b; v = (a[31] == b[31]) && (s[31] != a[31]); end
      OP_SUB:  begin s = a - b; v = (a[31] != b[31]) && (s[31] != a[31]); end
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_XOR:  s = a ^ b;
      OP_SLT:  s = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: s = {31'd0, a < b};
      default: s = 32'd0;
    endcase
    return {v, s};
  endfunction

  always_comb {alu_overflow, alu_out} = alu_f(alu_a, alu_b, alu_ctrl);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registers.
  task automatic step(input logic iv0, input logic [31:0] ia0, input logic [31:0] ib0,
                      input logic [3:0] ic0,
                      input logic iv1, input logic [31:0] ia1, input logic [31:0] ib1,
                      input logic [3:0] ic1,
                      input logic irr, input logic ifl);
    logic        ci;
    int          g;
    logic [32:0] r;
    req0_valid = iv0; req0_a = ia0; req0_b = ib0; req0_ctrl = ic0;
    req1_valid = iv1; req1_a = ia1; req1_b = ib1; req1_ctrl = ic1;
    rsp_ready  = irr; flush = ifl;
    #1;
    ci = !ifl && (exp_q.size() == 0 || irr);
    g  = -1;
    if (ci) begin
      if (iv0 && iv1) g = (m_last == 1'b0) ? 1 : 0;
      else if (iv0)   g = 0;
      else if (iv1)   g = 1;
    end
    chk("req0_ready", req0_ready, g == 0);
    chk("req1_ready", req1_ready, g == 1);
    chk("alu_a",    alu_a,    (g == 0) ? ia0 : (g == 1) ? ia1 : 32'd0);
    chk("alu_b",    alu_b,    (g == 0) ? ib0 : (g == 1) ? ib1 : 32'd0);
    chk("alu_ctrl", alu_ctrl, (g == 0) ? ic0 : (g == 1) ? ic1 : PARK);
    @(posedge clk);
    if (ifl) begin
      exp_q.delete();
    end else if (g >= 0) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      r = (g == 0) ? alu_f(ia0, ib0, ic0) : alu_f(ia1, ib1, ic1);
      exp_q.push_back({g[0], r});
      m_last = g[0];
    end else if (exp_q.size() != 0 && irr) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk("rsp_valid", rsp_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      chk("rsp_id_ovf_data", {rsp_id, rsp_overflow, rsp_data}, exp_q[0]);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    reset = 1'b1; m_last = 1'b1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
    rsp_ready = 0; flush = 0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_ovf", rsp_overflow, 1'b0);
    chk("reset_req0_ready", req0_ready, 1'b0);
    chk("reset_alu_ctrl", alu_ctrl, PARK);
    @(negedge clk);
    reset = 1'b0;

    // First op after reset: 5 + 7.
    step(1, 32'd5, 32'd7, OP_ADD, 0, 0, 0, OP_ADD, 1, 0);
    chk("first_data", rsp_data, 32'd12);
    chk("first_id", rsp_id, 1'b0);

    // Contention every cycle: grants must alternate.
    for (int i = 0; i < 4; i++)
      step(1, 32'd10, 32'd3, OP_SUB, 1, 32'hF0, 32'h0F, OP_OR, 1, 0);

    // Signed overflow from requester 1.
    step(0, 0, 0, OP_ADD, 1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 1, 0);
    chk("ovf_data", rsp_data, 32'h8000_0000);
    chk("ovf_flag", rsp_overflow, 1'b1);
    chk("ovf_id", rsp_id, 1'b1);

    // Backpressure: held response, req0 waits three cycles then issues.
    for (int i = 0; i < 3; i++)
      step(1, 32'd1, 32'd2, OP_XOR, 0, 0, 0, OP_ADD, 0, 0);
    step(1, 32'd1, 32'd2, OP_XOR, 0, 0, 0, OP_ADD, 1, 0);
    chk("bp_data", rsp_data, 32'd3);

    // Flush while full with req1 waiting, then resume.
    step(0, 0, 0, OP_ADD, 1, 32'd9, 32'd4, OP_SLTU, 1, 1);
    step(0, 0, 0, OP_ADD, 1, 32'd9, 32'd4, OP_SLTU, 0, 0);
    step(1, 32'hFFFF_FFFF, 32'd1, OP_SLT, 1, 32'd6, 32'd6, OP_AND, 1, 0);

    // Random traffic with occasional backpressure and flushes.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 4'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), pick_operand(), pick_operand(), 4'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Async reset between edges while full.
    step(1, 32'd2, 32'd2, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    step(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0);
    chk("pre_reset_full", rsp_valid, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", rsp_valid, 1'b0);
    exp_q.delete();
    m_last = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    step(1, 32'd4, 32'd1, OP_SUB, 1, 32'd8, 32'd8, OP_ADD, 1, 0);
    chk("post_reset_winner", rsp_id, 1'b0);
    step(0, 0, 0, OP_ADD, 0, 0, 0, OP_ADD, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
